jtag_dr_bank: RTL
=================

Name: jtag_dr_bank

Overview:
- Parametrised data-register engine behind the virtual JTAG TAP. Runs entirely in the tck domain.
- Decodes the TAP IR into NUM_REGS data registers of DR_WIDTH bits each.
- Handles capture, LSB-first shift and update of the selected register, and drives tdo.
- Emits a one-tck update strobe with the shifted word. Downstream logic (system-side clock crossing) consumes it.
- Unmapped IR codes fall back to a 1-bit bypass register.

Parameters:
- IR_LENGTH, 8, width of the ir input.
- DR_WIDTH, 32, width of every data register.
- NUM_REGS, 8, number of mapped data registers (1..2^IR_LENGTH).
- IR_BASE, 1, IR code of register 0; register k selected when ir == IR_BASE+k.
- CNT_WIDTH, 8, width of the shift counter (saturating).

Ports:
- tck  input  1  JTAG clock, sole clock.
- reset_n  input  1  asynchronous active-low reset.
- ir  input  IR_LENGTH  current instruction from the TAP.
- capture_dr  input  1  TAP in Capture-DR.
- shift_dr  input  1  TAP in Shift-DR.
- update_dr  input  1  TAP in Update-DR.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out.
- capture_data  input  NUM_REGS*DR_WIDTH  parallel capture values; slice k belongs to register k.
- update_data  output  DR_WIDTH  last completed shift word.
- update_sel  output  NUM_REGS  one-hot strobe of the updated register, 1 tck wide.
- shift_count  output  CNT_WIDTH  number of bits shifted since last capture.
- len_error  output  1  sticky length error; only present with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (async, reset_n low): shreg=0, bypass=0, sel_idx=0, sel_valid=0, update_data=0, update_sel=0, shift_count=0, len_error=0. tdo reads 0.
- All other state updates on the tck rising edge.
- Priority, highest first: capture_dr > shift_dr > update_dr. Any two asserted together → only the highest acts.
- Capture:
  - Decode ir. If IR_BASE <= ir < IR_BASE+NUM_REGS: sel_idx = ir-IR_BASE, sel_valid=1, shreg = capture_data slice sel_idx.
  - Otherwise: sel_valid=0, bypass=0.
  - shift_count=0 in both cases.
- Selection is latched at capture. Changes on ir after capture are ignored until the next capture.
- Shift:
  - If sel_valid: shreg = {tdi, shreg[DR_WIDTH-1:1]}.
  - Else: bypass = tdi.
  - shift_count increments and saturates at 2^CNT_WIDTH-1, with no wrap.
- tdo is combinational: shreg[0] when sel_valid, else bypass. At the start of Shift-DR, tdo shows captured bit 0.
- No shift_dr (pause/exit states): shreg and count hold.
- Update:
  - If sel_valid: update_data = shreg, and update_sel = one-hot(sel_idx) for exactly the following tck cycle, then returns to 0.
  - If not sel_valid: update_sel stays 0 and update_data holds.
- update_dr held high for N cycles produces a single 1-cycle strobe. The strobe fires on the rising edge of update_dr only, tracked by a registered previous-update flag.
- More than DR_WIDTH shifts: the last DR_WIDTH tdi bits remain, and earlier bits exit on tdo (pass-through).
- Fewer than DR_WIDTH shifts: the upper captured bits remain in the word, right-shifted.
- Reset mid-shift: all state clears immediately. A following update_dr without a new capture produces no strobe, because sel_valid=0.

Optional Feature:
- Macro: JTAG_DR_LEN_CHECK_EN.
- Defined:
  - On update with sel_valid, if shift_count != DR_WIDTH: no strobe, update_data holds, and len_error sets sticky.
  - len_error clears only on reset, or on a capture with ir == IR_BASE+NUM_REGS (the reserved clear code, treated as bypass).
  - shift_count == DR_WIDTH: normal update.
- Undefined: any shift length updates normally, and len_error is constant 0.

Test Plan:
- Reset then capture with ir=IR_BASE+2, capture_data slice2=0xDEADBEEF, shift 32 bits of tdi=0x12345678 LSB first → tdo yields 0xDEADBEEF LSB first; on update, update_data=0x12345678 and update_sel=0x04 for exactly one tck.
- ir=0x00 (unmapped) capture, shift pattern 1,0,1 → tdo lags tdi by one cycle with first bit 0; no update_sel pulse on update.
- Capture reg0 with 0xFFFFFFFF, shift 8 bits 0x00 → update_data=0x00FFFFFF (feature off); with JTAG_DR_LEN_CHECK_EN, no strobe and len_error=1.
- capture_dr and shift_dr asserted together with ir=IR_BASE → shreg loads capture value, shift_count stays 0; update_dr held 3 cycles → a single 1-cycle strobe.
- Change ir mid-shift to IR_BASE+5 after capture on IR_BASE+1 → update_sel=0x02.
- Shift 300 bits → shift_count saturates at 255; assert reset_n low mid-shift → all outputs 0 asynchronously; a following update yields no strobe.

Source files
------------

// File: rtl/jtag_dr_bank.sv
// ---------------------------------------------------------------------------------------------
// jtag_dr_bank
//
// Data-register engine behind a virtual JTAG TAP. Runs entirely in the tck domain.
// The TAP instruction is decoded into NUM_REGS data registers of DR_WIDTH bits each. The
// selected register is captured, shifted LSB-first and updated. Unmapped codes fall back to
// a 1-bit bypass register. A completed update emits a one-tck one-hot strobe together with
// the shifted word, for a downstream clock-domain crossing to consume.
//
// Optional feature (macro JTAG_DR_LEN_CHECK_EN):
//   An update is accepted only after exactly DR_WIDTH shifts. Otherwise the strobe is
//   suppressed, update_data holds, and the sticky len_error flag sets. len_error is cleared
//   by reset or by a capture with ir == IR_BASE+NUM_REGS (this code behaves as bypass).
//   Without the macro, any shift length updates and len_error is tied to 0.
//
// Ports:
//   tck           JTAG clock, sole clock
//   reset_n       asynchronous active-low reset
//   ir            current instruction from the TAP
//   capture_dr    TAP in Capture-DR
//   shift_dr      TAP in Shift-DR
//   update_dr     TAP in Update-DR
//   tdi           serial data in
//   tdo           serial data out (combinational from state)
//   capture_data  parallel capture values, slice k belongs to register k
//   update_data   last completed shift word
//   update_sel    one-hot strobe of the updated register, one tck wide
//   shift_count   bits shifted since last capture, saturating
//   len_error     sticky length error (feature only, else 0)
//
// DR_WIDTH must be at least 2.
// ---------------------------------------------------------------------------------------------

module jtag_dr_bank #(
    parameter int unsigned IR_LENGTH = 8,
    parameter int unsigned DR_WIDTH  = 32,
    parameter int unsigned NUM_REGS  = 8,
    parameter int unsigned IR_BASE   = 1,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                         tck,
    input  logic                         reset_n,
    input  logic [IR_LENGTH-1:0]         ir,
    input  logic                         capture_dr,
    input  logic                         shift_dr,
    input  logic                         update_dr,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [NUM_REGS*DR_WIDTH-1:0] capture_data,
    output logic [DR_WIDTH-1:0]          update_data,
    output logic [NUM_REGS-1:0]          update_sel,
    output logic [CNT_WIDTH-1:0]         shift_count,
    output logic                         len_error
);

    localparam int unsigned IdxWidth = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // State
    logic [DR_WIDTH-1:0]  shreg_q,       shreg_d;
    logic                 bypass_q,      bypass_d;
    logic [IdxWidth-1:0]  sel_idx_q,     sel_idx_d;
    logic                 sel_valid_q,   sel_valid_d;
    logic [DR_WIDTH-1:0]  update_data_q, update_data_d;
    logic [NUM_REGS-1:0]  update_sel_q,  update_sel_d;
    logic [CNT_WIDTH-1:0] shift_count_q, shift_count_d;
    logic                 upd_prev_q,    upd_prev_d;

    // Instruction decode
    logic [31:0]          ir_ext;
    logic                 ir_hit;
    logic [IdxWidth-1:0]  ir_idx;
    logic [DR_WIDTH-1:0]  cap_words [NUM_REGS];
    logic                 upd_rise;

    assign ir_ext = 32'(ir);
    assign ir_hit = (ir_ext >= IR_BASE) && (ir_ext < IR_BASE + NUM_REGS);
    assign ir_idx = IdxWidth'(ir_ext - IR_BASE);

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_cap_words
        assign cap_words[k] = capture_data[k*DR_WIDTH +: DR_WIDTH];
    end

    // Update acts only on the first cycle of an update_dr pulse, and only when neither
    // capture nor shift has priority in that cycle.
    assign upd_rise = update_dr && !capture_dr && !shift_dr && !upd_prev_q;

`ifdef JTAG_DR_LEN_CHECK_EN
    logic len_err_q, len_err_d;
    logic ir_clr;
    logic len_ok;

    assign ir_clr = (ir_ext == IR_BASE + NUM_REGS);
    assign len_ok = (32'(shift_count_q) == DR_WIDTH);
`endif

    always_comb begin
        shreg_d       = shreg_q;
        bypass_d      = bypass_q;
        sel_idx_d     = sel_idx_q;
        sel_valid_d   = sel_valid_q;
        update_data_d = update_data_q;
        update_sel_d  = '0;
        shift_count_d = shift_count_q;
        upd_prev_d    = update_dr;
`ifdef JTAG_DR_LEN_CHECK_EN
        len_err_d     = len_err_q;
`endif

        if (capture_dr) begin
            if (ir_hit) begin
                sel_idx_d   = ir_idx;
                sel_valid_d = 1'b1;
                shreg_d     = cap_words[ir_idx];
            end else begin
                sel_valid_d = 1'b0;
                bypass_d    = 1'b0;
`ifdef JTAG_DR_LEN_CHECK_EN
                if (ir_clr) begin
                    len_err_d = 1'b0;
                end
`endif
            end
            shift_count_d = '0;
        end else if (shift_dr) begin
            if (sel_valid_q) begin
                shreg_d = {tdi, shreg_q[DR_WIDTH-1:1]};
            end else begin
                bypass_d = tdi;
            end
            // Saturate rather than wrap so over-long shifts stay visible.
            if (shift_count_q != '1) begin
                shift_count_d = shift_count_q + CNT_WIDTH'(1);
            end
        end else if (upd_rise && sel_valid_q) begin
`ifdef JTAG_DR_LEN_CHECK_EN
            if (len_ok) begin
                update_data_d = shreg_q;
                update_sel_d  = NUM_REGS'(1) << sel_idx_q;
            end else begin
                len_err_d = 1'b1;
            end
`else
            update_data_d = shreg_q;
            update_sel_d  = NUM_REGS'(1) << sel_idx_q;
`endif
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q       <= '0;
            bypass_q      <= 1'b0;
            sel_idx_q     <= '0;
            sel_valid_q   <= 1'b0;
            update_data_q <= '0;
            update_sel_q  <= '0;
            shift_count_q <= '0;
            upd_prev_q    <= 1'b0;
        end else begin
            shreg_q       <= shreg_d;
            bypass_q      <= bypass_d;
            sel_idx_q     <= sel_idx_d;
            sel_valid_q   <= sel_valid_d;
            update_data_q <= update_data_d;
            update_sel_q  <= update_sel_d;
            shift_count_q <= shift_count_d;
            upd_prev_q    <= upd_prev_d;
        end
    end

`ifdef JTAG_DR_LEN_CHECK_EN
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            len_err_q <= 1'b0;
        end else begin
            len_err_q <= len_err_d;
        end
    end

    assign len_error = len_err_q;
`else
    assign len_error = 1'b0;
`endif

    // Outputs
    assign tdo         = sel_valid_q ? shreg_q[0] : bypass_q;
    assign update_data = update_data_q;
    assign update_sel  = update_sel_q;
    assign shift_count = shift_count_q;

endmodule
